// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central pipeline sequencer for the 5-stage MIPS core.
//               - Detects ID-stage data hazards and generates the load-use
//                 freeze of PC/IF-ID and the ID/EXE bubble.
//               - Generates the branch flush of IF/ID and ID/EXE.
//               - Selects the EXE operand forwarding sources.
//               - Runs the wait-state FSM for the handshaked SRAM in MEM,
//                 with a sticky timeout error.
//               - Keeps a saturating stall-cycle performance counter.
// Ports       :
//   clk, rst (async, active-low)
//   forward_en, src1, src2, two_src                    ID-stage operands
//   exe_dest, exe_wb_en, exe_mem_r_en                  ID/EXE producer
//   exe_src1, exe_src2                                 EXE-stage consumers
//   mem_dest, mem_wb_en / wb_dest, wb_wb_en            later producers
//   br_taken, mem_req, mem_ready, cnt_clr              control inputs
//   freeze_pipe, freeze_if, id_bubble, flush           stage controls
//   sram_start, fwd_sel_a, fwd_sel_b                   datapath controls
//   mem_err, stall_cnt                                 status
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             two_src,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       exe_src1,
    input  logic [4:0]       exe_src2,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [4:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             freeze_pipe,
    output logic             freeze_if,
    output logic             id_bubble,
    output logic             flush,
    output logic             sram_start,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] C_FWD_REG = 2'd0;
    localparam logic [1:0] C_FWD_MEM = 2'd1;
    localparam logic [1:0] C_FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic                err_q,   err_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    logic                w_mem_busy;
    logic                w_hazard;
    logic                w_flush;
    logic                w_freeze_if;

    // A producer only matches a consumer when it will write back and its
    // destination is not R0 (R0 is hard-wired to zero).
    function automatic logic f_match(input logic       wb_en,
                                     input logic [4:0] dest,
                                     input logic [4:0] src);
        return wb_en && (dest != 5'd0) && (dest == src);
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        w_hazard = 1'b0;
        if (forward_en) begin
            // With forwarding only a load in EXE cannot be bypassed in time.
            w_hazard = exe_mem_r_en &&
                       (f_match(exe_wb_en, exe_dest, src1) ||
                        (two_src && f_match(exe_wb_en, exe_dest, src2)));
        end else begin
            w_hazard = f_match(exe_wb_en, exe_dest, src1) ||
                       f_match(mem_wb_en, mem_dest, src1) ||
                       (two_src && (f_match(exe_wb_en, exe_dest, src2) ||
                                    f_match(mem_wb_en, mem_dest, src2)));
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects (MEM result is younger, so it wins over WB)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_sel_a = C_FWD_REG;
        fwd_sel_b = C_FWD_REG;
        if (forward_en) begin
            if (f_match(mem_wb_en, mem_dest, exe_src1))
                fwd_sel_a = C_FWD_MEM;
            else if (f_match(wb_wb_en, wb_dest, exe_src1))
                fwd_sel_a = C_FWD_WB;

            if (f_match(mem_wb_en, mem_dest, exe_src2))
                fwd_sel_b = C_FWD_MEM;
            else if (f_match(wb_wb_en, wb_dest, exe_src2))
                fwd_sel_b = C_FWD_WB;
        end
    end

    // ------------------------------------------------------------------
    // SRAM wait-state FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        err_d      = err_q;
        sram_start = 1'b0;
        w_mem_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Busy is asserted in the request cycle itself so the
                // pipeline freezes before the access is even started.
                if (mem_req) begin
                    sram_start = 1'b1;
                    w_mem_busy = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_mem_busy = 1'b1;
                wait_d     = wait_q + 1'b1;
                if (mem_ready) begin
                    state_d = ST_DONE;
                end else if (wait_q == C_WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // One unfrozen cycle lets the memory instruction retire;
                // its still-asserted mem_req must not restart an access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage controls: memory freeze > branch flush > hazard stall
    // ------------------------------------------------------------------
    assign freeze_pipe = w_mem_busy;
    assign w_flush     = br_taken & ~w_mem_busy;
    assign w_freeze_if = w_hazard & ~w_mem_busy & ~w_flush;
    assign flush       = w_flush;
    assign freeze_if   = w_freeze_if;
    assign id_bubble   = w_freeze_if;
    assign mem_err     = err_q;

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if ((w_mem_busy || w_freeze_if) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl
//               (TIMEOUT=4, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             forward_en, two_src, exe_wb_en, exe_mem_r_en;
    logic [4:0]       src1, src2, exe_dest, exe_src1, exe_src2, mem_dest, wb_dest;
    logic             mem_wb_en, wb_wb_en, br_taken, mem_req, mem_ready, cnt_clr;
    logic             freeze_pipe, freeze_if, id_bubble, flush, sram_start, mem_err;
    logic [1:0]       fwd_sel_a, fwd_sel_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [4:0]       ctl;

    int checks = 0;
    int errors = 0;

    // {freeze_pipe, freeze_if, id_bubble, flush, sram_start}
    assign ctl = {freeze_pipe, freeze_if, id_bubble, flush, sram_start};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .forward_en(forward_en), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_src1(exe_src1), .exe_src2(exe_src2),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr),
        .freeze_pipe(freeze_pipe), .freeze_if(freeze_if), .id_bubble(id_bubble),
        .flush(flush), .sram_start(sram_start),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic idle_inputs();
        forward_en = 1'b0; two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        src1 = '0; src2 = '0; exe_dest = '0; exe_src1 = '0; exe_src2 = '0;
        mem_dest = '0; wb_dest = '0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counter();
        next_cycle();
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if ({ctl, fwd_sel_a, fwd_sel_b, mem_err, stall_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b fa=%0d fb=%0d err=%b cnt=%0d required all 0",
                     ctl, fwd_sel_a, fwd_sel_b, mem_err, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        #1;
        checks++;
        if ({ctl, stall_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL after_reset_idle: got ctl=%b cnt=%0d required 0/0", ctl, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        clear_counter();
        forward_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1;
        exe_dest = 5'd5; src1 = 5'd5;
        #1;
        checks++;
        if (ctl !== 5'b01100) begin
            errors++;
            $display("FAIL load_use_stall: got ctl=%b required 01100", ctl);
        end
        next_cycle();
        exe_mem_r_en = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_release: got ctl=%b cnt=%0d required 00000 cnt=1", ctl, stall_cnt);
        end
        // R0 destination never creates a hazard
        exe_mem_r_en = 1'b1; exe_dest = 5'd0; src1 = 5'd0;
        #1;
        checks++;
        if (freeze_if !== 1'b0) begin
            errors++;
            $display("FAIL load_use_r0: got freeze_if=%b required 0", freeze_if);
        end
        next_cycle();
        #1;
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_r0_cnt: got %0d required 1", stall_cnt);
        end
        // src2 only counts when two_src=1
        exe_dest = 5'd9; src1 = 5'd3; src2 = 5'd9; two_src = 1'b0;
        #1;
        checks++;
        if (freeze_if !== 1'b0) begin
            errors++;
            $display("FAIL src2_ignored: got freeze_if=%b required 0", freeze_if);
        end
        two_src = 1'b1;
        #1;
        checks++;
        if (id_bubble !== 1'b1) begin
            errors++;
            $display("FAIL src2_used: got id_bubble=%b required 1", id_bubble);
        end
        // No forwarding: a non-load EXE/MEM producer also stalls
        forward_en = 1'b0; exe_mem_r_en = 1'b0; exe_wb_en = 1'b0;
        two_src = 1'b0; src1 = 5'd12; mem_dest = 5'd12; mem_wb_en = 1'b1;
        #1;
        checks++;
        if (freeze_if !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_mem_hazard: got freeze_if=%b required 1", freeze_if);
        end
        mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 5'd12;
        #1;
        checks++;
        if (freeze_if !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_exe_hazard: got freeze_if=%b required 1", freeze_if);
        end
        idle_inputs();
    endtask

    task automatic test_forwarding();
        forward_en = 1'b1; mem_dest = 5'd7; wb_dest = 5'd7;
        mem_wb_en = 1'b1; wb_wb_en = 1'b1; exe_src1 = 5'd7;
        #1;
        checks++;
        if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL fwd_mem_priority: got a=%0d b=%0d required a=1 b=0", fwd_sel_a, fwd_sel_b);
        end
        mem_wb_en = 1'b0;
        #1;
        checks++;
        if (fwd_sel_a !== 2'd2) begin
            errors++;
            $display("FAIL fwd_wb: got a=%0d required 2", fwd_sel_a);
        end
        exe_src2 = 5'd7; mem_wb_en = 1'b1; mem_dest = 5'd8; exe_src1 = 5'd8;
        #1;
        checks++;
        if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd2) begin
            errors++;
            $display("FAIL fwd_both: got a=%0d b=%0d required a=1 b=2", fwd_sel_a, fwd_sel_b);
        end
        mem_dest = 5'd0; wb_dest = 5'd0; exe_src1 = 5'd0; exe_src2 = 5'd0;
        #1;
        checks++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL fwd_r0: got a=%0d b=%0d required 0 0", fwd_sel_a, fwd_sel_b);
        end
        mem_dest = 5'd7; wb_dest = 5'd7; exe_src1 = 5'd7; exe_src2 = 5'd7;
        forward_en = 1'b0;
        #1;
        checks++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL fwd_disabled: got a=%0d b=%0d required 0 0", fwd_sel_a, fwd_sel_b);
        end
        idle_inputs();
    endtask

    task automatic test_sram_wait();
        clear_counter();
        mem_req = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b10001) begin
            errors++;
            $display("FAIL sram_idle_start: got ctl=%b required 10001", ctl);
        end
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            mem_ready = (i == 3);
            #1;
            checks++;
            if (ctl !== 5'b10000) begin
                errors++;
                $display("FAIL sram_busy_%0d: got ctl=%b required 10000", i, ctl);
            end
        end
        next_cycle();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000 || stall_cnt !== 4'd4 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL sram_done: got ctl=%b cnt=%0d err=%b required 00000 cnt=4 err=0",
                     ctl, stall_cnt, mem_err);
        end
        next_cycle();
        mem_req = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000 || stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL sram_back_idle: got ctl=%b cnt=%0d required 00000 cnt=4", ctl, stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_branch_stall();
        mem_req = 1'b1; br_taken = 1'b1;
        forward_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1;
        exe_dest = 5'd5; src1 = 5'd5;
        #1;
        checks++;
        if (ctl !== 5'b10001) begin
            errors++;
            $display("FAIL branch_idle_frozen: got ctl=%b required 10001", ctl);
        end
        next_cycle();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b10000) begin
            errors++;
            $display("FAIL branch_busy_no_flush: got ctl=%b required 10000", ctl);
        end
        next_cycle();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00010) begin
            errors++;
            $display("FAIL branch_done_flush: got ctl=%b required 00010", ctl);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_timeout();
        mem_req = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b10001) begin
            errors++;
            $display("FAIL timeout_start: got ctl=%b required 10001", ctl);
        end
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            #1;
            checks++;
            if (ctl !== 5'b10000 || mem_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_busy_%0d: got ctl=%b err=%b required 10000 err=0", i, ctl, mem_err);
            end
        end
        next_cycle();
        #1;
        checks++;
        if (ctl !== 5'b00000 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: got ctl=%b err=%b required 00000 err=1", ctl, mem_err);
        end
        next_cycle();
        mem_req = 1'b0;
        #1;
        checks++;
        if (mem_err !== 1'b1 || ctl !== 5'b00000) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b ctl=%b required err=1 ctl=00000", mem_err, ctl);
        end
        // New access, then async reset in the middle of BUSY
        mem_req = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (ctl !== 5'b10000) begin
            errors++;
            $display("FAIL busy_no_repulse: got ctl=%b required 10000", ctl);
        end
        #1;
        rst = 1'b0;
        mem_req = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000 || mem_err !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_busy: got ctl=%b err=%b cnt=%0d required 00000 0 0",
                     ctl, mem_err, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b10001) begin
            errors++;
            $display("FAIL restart_after_reset: got ctl=%b required 10001", ctl);
        end
        next_cycle();
        mem_req = 1'b0;
        next_cycle();
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_counter();
        clear_counter();
        forward_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1;
        exe_dest = 5'd3; src1 = 5'd3;
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd14) begin
            errors++;
            $display("FAIL counter_14: got %0d required 14", stall_cnt);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL counter_saturate: got %0d required 15", stall_cnt);
        end
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
        exe_mem_r_en = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL counter_clear: got %0d required 0", stall_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_sram_wait();
        test_branch_stall();
        test_timeout();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It drives freeze, bubble and flush controls for the IF/ID/EXE/MEM stage registers, including the flush input of the ID/EXE register. It selects EXE operand forwarding sources and runs a wait-state FSM for the handshaked SRAM used by the MEM stage. It also keeps a saturating stall-cycle performance counter.

Parameters:
TIMEOUT, 64, max BUSY cycles waiting for mem_ready before abort (>=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
forward_en  in  1  1 = forwarding enabled
src1  in  5  ID-stage source register 1
src2  in  5  ID-stage source register 2
two_src  in  1  ID instruction reads src2
exe_dest  in  5  dest in ID/EXE register
exe_wb_en  in  1  WB_EN in ID/EXE register
exe_mem_r_en  in  1  MEM_R_EN in ID/EXE register
exe_src1  in  5  src1 of instruction in EXE
exe_src2  in  5  src2 of instruction in EXE
mem_dest  in  5  dest in EXE/MEM register
mem_wb_en  in  1  WB_EN in EXE/MEM register
wb_dest  in  5  dest in MEM/WB register
wb_wb_en  in  1  WB_EN in MEM/WB register
br_taken  in  1  branch taken, from EXE stage
mem_req  in  1  MEM_R_EN or MEM_W_EN of instruction in MEM
mem_ready  in  1  SRAM access complete
cnt_clr  in  1  synchronous clear of stall counter
freeze_pipe  out  1  hold PC and all stage registers
freeze_if  out  1  hold PC and IF/ID register (load-use stall)
id_bubble  out  1  force zero control into ID/EXE register
flush  out  1  flush IF/ID and ID/EXE registers
sram_start  out  1  one-cycle SRAM access start pulse
fwd_sel_a  out  2  EXE operand A source: 0 reg, 1 EXE/MEM, 2 MEM/WB
fwd_sel_b  out  2  EXE operand B / store data source, same encoding
mem_err  out  1  sticky SRAM timeout flag
stall_cnt  out  CNT_W  cycles with freeze_pipe or freeze_if asserted, saturating

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, wait counter=0, mem_err=0, stall_cnt=0. All combinational outputs evaluate to 0 given idle inputs.
- A register match requires the producer's WB_EN=1 and dest!=0. R0 never matches.
- Hazard, forward_en=1: exe_mem_r_en & match(exe_dest) on src1, or on src2 when two_src=1.
- Hazard, forward_en=0: match(exe_dest) or match(mem_dest) on src1/src2 under the same two_src rule.
- FSM states:
  - IDLE: mem_req=1 → sram_start=1, mem_busy=1, next state BUSY, wait counter cleared.
  - BUSY: mem_busy=1, wait counter increments. mem_ready=1 → DONE. Counter reaching TIMEOUT-1 without ready → set mem_err, go to DONE.
  - DONE: mem_busy=0 for exactly one cycle so the pipeline advances; next state IDLE. mem_req is ignored in DONE.
- freeze_pipe = mem_busy. It is combinational, so it asserts in the same cycle mem_req rises in IDLE.
- flush = br_taken & ~freeze_pipe. A branch held in EXE during a memory stall flushes on the first unfrozen cycle.
- freeze_if = id_bubble = hazard & ~freeze_pipe & ~flush. Flush beats hazard.
- Forwarding, when forward_en=1:
  - fwd_sel_a = 1 if match(mem_dest) on exe_src1; else 2 if match(wb_dest); else 0. MEM has priority over WB.
  - fwd_sel_b: same rule on exe_src2.
  - When forward_en=0, both selects are 0.
- stall_cnt:
  - cnt_clr has priority: the counter becomes 0 next cycle.
  - Otherwise it increments when freeze_pipe|freeze_if, and saturates at all-ones.
- mem_err clears only on reset.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately. sram_start does not re-pulse until a new IDLE with mem_req.

Test Plan:
- Load-use: exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src1=5, forward_en=1 → freeze_if=1 and id_bubble=1 for 1 cycle, stall_cnt=1. Repeat with exe_dest=0 → no stall.
- Forwarding: mem_dest=wb_dest=7, both WB_EN=1, exe_src1=7 → fwd_sel_a=1. Drop mem_wb_en → fwd_sel_a=2. forward_en=0 → 0.
- SRAM wait: mem_req=1, mem_ready after 3 BUSY cycles → sram_start pulses once in cycle 0, freeze_pipe=1 for 4 cycles, then 0 in DONE, FSM returns to IDLE.
- Branch during stall: br_taken=1 while BUSY → flush=0 until DONE cycle, then flush=1. Simultaneous hazard → freeze_if=0.
- Timeout: TIMEOUT=4, mem_ready held 0 → DONE after 4 BUSY cycles, mem_err=1 stays set; async rst=0 mid-BUSY → state IDLE, mem_err=0, stall_cnt=0.
- Counter: CNT_W=4, continuous stall 20 cycles → stall_cnt=15. cnt_clr=1 → 0 next cycle.
